// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path (and a future receive path).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;
    localparam int UART_BITS_PER_FRAME       = 10;
    localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes written by main_mem are queued and shifted out
// LSB first on tx, with back-to-back frames when data is pending.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_active,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_t   state, state_next;
    logic [BW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic          tx_q, tx_next;
    logic          overflow_q;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rd_data;
    logic          bit_end;

    // Write handshake: wr_en is a one-cycle strobe with no ready; the byte is taken on
    // the edge where busy (pre-edge FIFO full) is low, otherwise it is dropped and
    // overflow latches until reset.
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_en),
        .pop     (fifo_pop),
        .wr_data (wr_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign busy      = fifo_full;
    assign overflow  = overflow_q;
    assign tx        = tx_q;
    assign tx_active = (state != IDLE);
    assign bit_end   = (baud_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            tx_q     <= tx_next;
            if (wr_en && fifo_full) overflow_q <= 1'b1;
        end
    end

    // tx_next is the line level for the bit being entered, so tx stays a clean flop output.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        tx_next    = tx_q;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_rd_data;
                    tx_next    = 1'b0;
                    baud_next  = BAUD_LAST;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    bit_next   = '0;
                    tx_next    = shift[0];
                    baud_next  = BAUD_LAST;
                end else begin
                    baud_next = baud_cnt - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = BAUD_LAST;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        shift_next = {1'b0, shift[7:1]};
                        bit_next   = bit_idx + 1'b1;
                        tx_next    = shift[1];
                    end
                end else begin
                    baud_next = baud_cnt - 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_rd_data;
                        tx_next    = 1'b0;
                        baud_next  = BAUD_LAST;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt - 1'b1;
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based line model checked every cycle, a line decoder,
// directed scenarios with literal expectations, then randomized writes.
module tb_uart_tx_fifo;

    localparam int C  = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          tx;
    logic          busy;
    logic          tx_active;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    uart_tx_fifo #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .tx         (tx),
        .busy       (busy),
        .tx_active  (tx_active),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // behavioural model: byte queue plus position inside the current frame
    logic [7:0] exp_q[$];
    bit         m_active = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_ovf = 1'b0;
    int         m_pre;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
        end else begin
            m_pre = exp_q.size();
            if (m_active) begin
                m_pos++;
                if (m_pos == 10 * C) begin
                    if (m_pre > 0) begin
                        m_byte = exp_q.pop_front();
                        m_pos  = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end else if (m_pre > 0) begin
                m_byte   = exp_q.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
            if (wr_en) begin
                if (m_pre == D) m_ovf = 1'b1;
                else exp_q.push_back(wr_data);
            end
        end
    end

    function automatic logic line_bit(int pos, logic [7:0] b);
        int k;
        k = pos / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx", tx, m_active ? line_bit(m_pos, m_byte) : 1'b1);
            check("tx_active", tx_active, m_active);
            check("fifo_count", fifo_count, exp_q.size());
            check("busy", busy, exp_q.size() == D);
            check("overflow", overflow, m_ovf);
        end
    end

    // line decoder: mid-bit sampling, logs frame start cycles and received bytes
    logic [7:0] rx_q[$];
    int         start_q[$];
    bit         in_frame = 1'b0;
    int         rx_pos = 0;
    int         rx_k;
    logic [7:0] rx_byte = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx === 1'b0) begin
                in_frame = 1'b1;
                rx_pos   = 0;
                start_q.push_back(cyc);
            end
        end else begin
            rx_pos++;
            if (rx_pos % C == C / 2) begin
                rx_k = rx_pos / C;
                if (rx_k >= 1 && rx_k <= 8) rx_byte[rx_k-1] = tx;
                else if (rx_k == 9) check("stop_bit", tx, 1'b1);
            end
            if (rx_pos == 10 * C - 1) begin
                in_frame = 1'b0;
                rx_q.push_back(rx_byte);
            end
        end
    end

    // driver tasks
    task automatic put(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            wr_en = 1'b0;
        end
    endtask

    task automatic reset_pulse();
        #2 reset = 1'b1;
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_count", fifo_count, 0);
        check("reset_active", tx_active, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic clear_logs();
        rx_q.delete();
        start_q.delete();
    endtask

    int          wcyc;
    logic [39:0] cap;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_active", tx_active, 1'b0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 1'b0);
        reset  = 1'b0;
        chk_en = 1'b1;
        wait_cycles(2);

        // single byte 0x44
        clear_logs();
        put(8'h44);
        wcyc = cyc + 1;
        wait_cycles(1);
        check("pre_fall_tx", tx, 1'b1);
        for (int i = 0; i < 40; i++) begin
            wait_cycles(1);
            cap[i] = tx;
        end
        check("frame_44", cap, 40'hF0F000F000);
        wait_cycles(1);
        check("active_after_44", tx_active, 1'b0);
        check("starts_44", start_q.size(), 1);
        if (start_q.size() > 0) check("start_latency", start_q[0] - wcyc, 1);
        check("rx_count_44", rx_q.size(), 1);
        if (rx_q.size() > 0) check("rx_44", rx_q[0], 8'h44);

        // two contiguous frames
        clear_logs();
        put(8'h11);
        put(8'h01);
        wait_cycles(90);
        check("starts_pair", start_q.size(), 2);
        if (start_q.size() == 2) check("pair_gap", start_q[1] - start_q[0], 40);
        check("rx_count_pair", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("rx_pair0", rx_q[0], 8'h11);
            check("rx_pair1", rx_q[1], 8'h01);
        end

        // overflow
        clear_logs();
        for (int i = 0; i < 5; i++) put(8'hA0 + 8'(i));
        @(negedge clk);
        check("ovf_count4", fifo_count, 4);
        check("ovf_busy", busy, 1'b1);
        check("ovf_before", overflow, 1'b0);
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        wait_cycles(1);
        check("ovf_set", overflow, 1'b1);
        check("ovf_count_hold", fifo_count, 4);
        wait_cycles(5 * 40 + 10);
        check("rx_count_ovf", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) check("rx_ovf", rx_q[i], 8'hA0 + 8'(i));
        end
        check("ovf_sticky", overflow, 1'b1);

        // reset mid-frame during data bit 3
        reset_pulse();
        check("ovf_cleared", overflow, 1'b0);
        clear_logs();
        put(8'h44);
        put(8'h12);
        put(8'h34);
        wait_cycles(16);
        check("mid_count", fifo_count, 2);
        check("mid_tx_bit3", tx, 1'b0);
        check("mid_active", tx_active, 1'b1);
        reset_pulse();
        clear_logs();
        put(8'h55);
        wait_cycles(50);
        check("starts_55", start_q.size(), 1);
        check("rx_count_55", rx_q.size(), 1);
        if (rx_q.size() > 0) check("rx_55", rx_q[0], 8'h55);

        // write landing in the last stop-bit cycle
        clear_logs();
        put(8'h3C);
        wait_cycles(39);
        put(8'hC3);
        wait_cycles(90);
        check("starts_late", start_q.size(), 2);
        if (start_q.size() == 2) check("late_gap", start_q[1] - start_q[0], 40);
        check("rx_count_late", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("rx_late0", rx_q[0], 8'h3C);
            check("rx_late1", rx_q[1], 8'hC3);
        end
        check("late_overflow", overflow, 1'b0);

        // randomized writes, one reset in the middle
        for (int it = 0; it < 1500; it++) begin
            if (it == 700) reset_pulse();
            if ($urandom_range(0, 99) < 30) put(8'($urandom_range(0, 255)));
            else wait_cycles(1);
        end
        wait_cycles(6 * 40);
        check("drain_count", fifo_count, 0);
        check("drain_active", tx_active, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Serial transmit stage downstream of `main_mem`. It accepts byte writes decoded by `main_mem` from the memory-mapped UART region at 0x8000_0000–0x8000_0003. Bytes are buffered in a small FIFO and shifted out as 8N1 frames on `tx`, which drives `main_mem`'s `uart_output`. Its `busy` flag drives `main_mem`'s `uart_busy`, so software can poll before storing.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434 — clock cycles per serial bit (50 MHz / 115200); must be ≥ 2.
- `FIFO_DEPTH`, default 4 — buffered bytes; power of 2, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `wr_en`  in  1  one-cycle store strobe from `main_mem` (UART address hit with `write_en`).
- `wr_data`  in  8  byte to send, taken from `data_in[7:0]`.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  FIFO full; a write this cycle is dropped.
- `tx_active`  out  1  a frame is being shifted.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
- `overflow`  out  1  sticky: a write arrived while `busy`; cleared only by `reset`.

## Operation
- Reset values: `tx`=1, `busy`=0, `tx_active`=0, `fifo_count`=0, `overflow`=0, FSM=IDLE, read and write pointers 0.
- Write acceptance:
  - `wr_en` with `busy`=0 pushes `wr_data`.
  - `wr_en` with `busy`=1 is discarded and sets `overflow`.
  - `busy` is evaluated from the pre-edge count, even if a pop occurs on the same edge.
- FIFO behaviour:
  - Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
  - `busy` = (`fifo_count` == FIFO_DEPTH).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into the shift register, drive `tx`=0, go to START. Otherwise hold `tx`=1.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right and increment the index. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). Reloads to CLKS_PER_BIT−1 on each bit entry, decrements to 0, and the bit ends at 0.
- `tx_active` is high in START, DATA and STOP.
- `tx` is driven from a register (glitch-free).
- Reset mid-frame aborts the frame: `tx` returns to 1 asynchronously and buffered bytes are lost.

## Timing
- Write-to-start latency:
  - `wr_en` sampled at edge N with an empty FIFO and FSM in IDLE.
  - Byte is stored at N, popped at N+1, and `tx` falls after N+1.
- Frame length: exactly 10·CLKS_PER_BIT cycles from the `tx` fall to the end of the stop bit.
- Back-to-back frames: with data pending, consecutive frames are contiguous; the next start bit begins on the cycle after the last stop-bit cycle.
- `busy`, `fifo_count` and `overflow` update on the same edge as the push or pop that changes them.

## Structure
- Package `uart_pkg`:
  - `uart_state_t` enum {IDLE, START, DATA, STOP}.
  - Constants `UART_DEFAULT_CLKS_PER_BIT`=434 and `UART_BITS_PER_FRAME`=10.
- Sub-module `sync_fifo`, parameterized by width and depth:
  - push/pop, full/empty, count.
  - Reuse it for a future RX path.
- Top level holds the FSM, baud counter, shift register and overflow flag.

## Test plan
All scenarios run with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset: assert `reset` for one cycle → `tx`=1, `busy`=0, `tx_active`=0, `fifo_count`=0, `overflow`=0.
- Single byte 0x44 (low byte of 0x01114444):
  - `tx` falls one cycle after the write edge.
  - Line sequence: 0 | 0,0,1,0,0,0,1,0 | 1, each bit for 4 cycles, 40 cycles total.
  - `tx_active` then drops.
- Two bytes 0x11 then 0x01 on consecutive cycles → two contiguous frames, 80 cycles, no idle cycle between the stop bit and the second start bit.
- Overflow: six writes (0xA0–0xA5) on consecutive cycles:
  - 0xA0 is popped; `fifo_count` reaches 4 and `busy`=1 after the fifth write.
  - The sixth write (0xA5) is dropped and `overflow`=1.
  - Exactly five frames appear, in order 0xA0–0xA4.
- Reset mid-frame: pulse `reset` during data bit 3 of 0x44 with two bytes queued:
  - `tx`=1 immediately and `fifo_count`=0.
  - A subsequent write of 0x55 produces one clean 40-cycle frame.
- Write during the last stop-bit cycle of an active frame → the new byte's start bit follows immediately with no gap; `overflow` stays 0.
